// File: rtl/dsp48a1_slice_pkg.sv
// Shared definitions for the DSP48A1-style slice: OPMODE bit fields,
// X/Z mux encodings, elaboration-time source codes and the post-adder helper.
package dsp48a1_slice_pkg;

  localparam int OP_X_LSB      = 0;
  localparam int OP_Z_LSB      = 2;
  localparam int OP_B1_PREADD  = 4;
  localparam int OP_CARRY      = 5;
  localparam int OP_PREADD_SUB = 6;
  localparam int OP_POST_SUB   = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

  localparam int B_SRC_DIRECT   = 0;
  localparam int B_SRC_CASCADE  = 1;
  localparam int B_SRC_ZERO     = 2;
  localparam int CY_SRC_OPMODE5 = 0;
  localparam int CY_SRC_CARRYIN = 1;
  localparam int CY_SRC_ZERO    = 2;

  // 49-bit post-adder; bit 48 is the carry when adding and the borrow when subtracting
  function automatic logic [48:0] post_add(input logic sub, input logic [47:0] z,
                                           input logic [47:0] x, input logic cin);
    logic [48:0] xc;
    xc = {1'b0, x} + {48'd0, cin};
    if (sub) begin
      return {1'b0, z} - xc;
    end else begin
      return {1'b0, z} + xc;
    end
  endfunction

endpackage

// File: rtl/dsp48a1_slice_reg_stage.sv
// One optional pipeline stage: a synchronous-reset, clock-enabled register
// when EN=1, a plain wire when EN=0.
module dsp_reg_stage #(
  parameter int WIDTH = 18,
  parameter bit EN    = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  if (EN) begin : g_reg
    logic [WIDTH-1:0] q_q;

    // Stage register: reset wins over clock enable, CE low holds
    always_ff @(posedge CLK) begin
      if (RST) begin
        q_q <= {WIDTH{1'b0}};
      end else if (CE) begin
        q_q <= D;
      end
    end

    assign Q = q_q;
  end else begin : g_bypass
    logic unused_ctrl_s;
    assign unused_ctrl_s = CLK ^ RST ^ CE;
    assign Q = D;
  end

endmodule

// File: rtl/dsp48a1_slice.sv
// Spartan-6-style DSP slice: D+/-B pre-adder, 18x18 unsigned multiplier and
// 48-bit post-adder/accumulator with per-stage optional registers.
module dsp48a1_slice
  import dsp48a1_slice_pkg::*;
#(
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT",
  parameter string RSTTYPE     = "SYNC"
) (
  input  logic        CLK,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic [17:0] BCIN,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic        CARRYOUT,
  output logic        CARRYOUTF,
  output logic [17:0] BCOUT,
  output logic [47:0] PCOUT
);

  if (RSTTYPE != "SYNC") begin : g_rsttype_check
    $error("dsp48a1_slice: only RSTTYPE \"SYNC\" is implemented");
  end

  localparam int B_SRC  = (B_INPUT == "DIRECT")     ? B_SRC_DIRECT :
                          (B_INPUT == "CASCADE")    ? B_SRC_CASCADE : B_SRC_ZERO;
  localparam int CY_SRC = (CARRYINSEL == "OPMODE5") ? CY_SRC_OPMODE5 :
                          (CARRYINSEL == "CARRYIN") ? CY_SRC_CARRYIN : CY_SRC_ZERO;

  logic [7:0]  opmode_q;
  logic [17:0] a0_q, a1_q, b0_d, b0_q, b1_d, b1_q, d_q, preadd_s;
  logic [35:0] m_d, m_q;
  logic [47:0] c_q, p_q, x_s, z_s;
  logic [48:0] post_s;
  logic        cyi_d, cyi_q, cyo_q;
  x_sel_e      x_sel_s;
  z_sel_e      z_sel_s;

  dsp_reg_stage #(.WIDTH(8), .EN(OPMODEREG != 0)) u_opmode (
    .CLK(CLK), .RST(RSTOPMODE), .CE(CEOPMODE), .D(OPMODE), .Q(opmode_q));

  // B operand source is fixed at elaboration
  always_comb begin
    b0_d = 18'd0;
    case (B_SRC)
      B_SRC_DIRECT:  b0_d = B;
      B_SRC_CASCADE: b0_d = BCIN;
      default:       b0_d = 18'd0;
    endcase
  end

  dsp_reg_stage #(.WIDTH(18), .EN(B0REG != 0)) u_b0 (
    .CLK(CLK), .RST(RSTB), .CE(CEB), .D(b0_d), .Q(b0_q));
  dsp_reg_stage #(.WIDTH(18), .EN(DREG != 0)) u_d (
    .CLK(CLK), .RST(RSTD), .CE(CED), .D(D), .Q(d_q));

  // Pre-adder wraps at 18 bits; OPMODE[4] decides whether it feeds B1
  always_comb begin
    preadd_s = 18'd0;
    b1_d     = 18'd0;
    if (opmode_q[OP_PREADD_SUB]) begin
      preadd_s = d_q - b0_q;
    end else begin
      preadd_s = d_q + b0_q;
    end
    if (opmode_q[OP_B1_PREADD]) begin
      b1_d = preadd_s;
    end else begin
      b1_d = b0_q;
    end
  end

  dsp_reg_stage #(.WIDTH(18), .EN(B1REG != 0)) u_b1 (
    .CLK(CLK), .RST(RSTB), .CE(CEB), .D(b1_d), .Q(b1_q));
  dsp_reg_stage #(.WIDTH(18), .EN(A0REG != 0)) u_a0 (
    .CLK(CLK), .RST(RSTA), .CE(CEA), .D(A), .Q(a0_q));
  dsp_reg_stage #(.WIDTH(18), .EN(A1REG != 0)) u_a1 (
    .CLK(CLK), .RST(RSTA), .CE(CEA), .D(a0_q), .Q(a1_q));

  assign m_d = {18'd0, a1_q} * {18'd0, b1_q};

  dsp_reg_stage #(.WIDTH(36), .EN(MREG != 0)) u_m (
    .CLK(CLK), .RST(RSTM), .CE(CEM), .D(m_d), .Q(m_q));
  dsp_reg_stage #(.WIDTH(48), .EN(CREG != 0)) u_c (
    .CLK(CLK), .RST(RSTC), .CE(CEC), .D(C), .Q(c_q));

  // Carry-in source; the OPMODE5 option follows the registered OPMODE
  always_comb begin
    cyi_d = 1'b0;
    case (CY_SRC)
      CY_SRC_OPMODE5: cyi_d = opmode_q[OP_CARRY];
      CY_SRC_CARRYIN: cyi_d = CARRYIN;
      default:        cyi_d = 1'b0;
    endcase
  end

  dsp_reg_stage #(.WIDTH(1), .EN(CARRYINREG != 0)) u_cyi (
    .CLK(CLK), .RST(RSTCARRYIN), .CE(CECARRYIN), .D(cyi_d), .Q(cyi_q));

  assign x_sel_s = x_sel_e'(opmode_q[OP_X_LSB +: 2]);
  assign z_sel_s = z_sel_e'(opmode_q[OP_Z_LSB +: 2]);

  // X and Z post-adder operand muxes; P feedback always taps the P stage output
  always_comb begin
    x_s = 48'd0;
    z_s = 48'd0;
    case (x_sel_s)
      X_ZERO:  x_s = 48'd0;
      X_M:     x_s = {12'd0, m_q};
      X_P:     x_s = p_q;
      X_DAB:   x_s = {d_q[11:0], a1_q, b1_q};
      default: x_s = 48'd0;
    endcase
    case (z_sel_s)
      Z_ZERO:  z_s = 48'd0;
      Z_PCIN:  z_s = PCIN;
      Z_P:     z_s = p_q;
      Z_C:     z_s = c_q;
      default: z_s = 48'd0;
    endcase
  end

  assign post_s = post_add(opmode_q[OP_POST_SUB], z_s, x_s, cyi_q);

  dsp_reg_stage #(.WIDTH(48), .EN(PREG != 0)) u_p (
    .CLK(CLK), .RST(RSTP), .CE(CEP), .D(post_s[47:0]), .Q(p_q));
  dsp_reg_stage #(.WIDTH(1), .EN(CARRYOUTREG != 0)) u_cyo (
    .CLK(CLK), .RST(RSTCARRYIN), .CE(CECARRYIN), .D(post_s[48]), .Q(cyo_q));

  assign M         = m_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign BCOUT     = b1_q;
  assign CARRYOUT  = cyo_q;
  assign CARRYOUTF = cyo_q;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Scoreboard bench for dsp48a1_slice: a history-based reference model pushes
// expected outputs per edge, a monitor pops and compares after each edge.
module tb_dsp48a1_slice;

  logic        CLK;
  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;
  logic [17:0] BCOUT;

  dsp48a1_slice dut (
    .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
    .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .D(D), .C(C), .BCIN(BCIN), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .OPMODE(OPMODE), .M(M), .P(P), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF),
    .BCOUT(BCOUT), .PCOUT(PCOUT));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [17:0] bcout;
    logic [35:0] m;
    logic [47:0] p;
    logic        co;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   k = 0;

  // Input history per edge index (inputs present before edge k) and model P/CO history
  localparam int N = 512;
  logic [17:0] h_a[N], h_b[N], h_d[N];
  logic [47:0] h_c[N], h_pcin[N];
  logic [7:0]  h_op[N];
  logic        h_rst[N], h_rstp[N], h_cep[N];
  logic [47:0] e_p[N];
  logic        e_co[N];

  task automatic cmp(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value held by each stage after edge j (all CEs high except P in this bench)
  function automatic logic [17:0] st_d(int j);  return h_rst[j] ? 18'd0 : h_d[j];  endfunction
  function automatic logic [17:0] st_a(int j);  return h_rst[j] ? 18'd0 : h_a[j];  endfunction
  function automatic logic [47:0] st_c(int j);  return h_rst[j] ? 48'd0 : h_c[j];  endfunction
  function automatic logic [7:0]  st_op(int j); return h_rst[j] ? 8'd0  : h_op[j]; endfunction

  function automatic logic st_cyi(int j);
    logic [7:0] o;
    if (h_rst[j]) return 1'b0;
    o = st_op(j - 1);
    return o[5];
  endfunction

  function automatic logic [17:0] st_b1(int j);
    logic [7:0]  o;
    logic [17:0] dd, pre;
    if (h_rst[j]) return 18'd0;
    o   = st_op(j - 1);
    dd  = st_d(j - 1);
    pre = o[6] ? dd - h_b[j] : dd + h_b[j];
    return o[4] ? pre : h_b[j];
  endfunction

  function automatic logic [35:0] st_m(int j);
    if (h_rst[j]) return 36'd0;
    return {18'd0, st_a(j - 1)} * {18'd0, st_b1(j - 1)};
  endfunction

  task automatic model_p(input int j);
    logic [7:0]  o;
    logic [17:0] dd;
    logic [47:0] xv, zv;
    logic [63:0] xx, zz, res;
    logic        cy;
    o  = st_op(j - 1);
    dd = st_d(j - 1);
    case (o[1:0])
      2'd0:    xv = 48'd0;
      2'd1:    xv = {12'd0, st_m(j - 1)};
      2'd2:    xv = e_p[j - 1];
      default: xv = {dd[11:0], st_a(j - 1), st_b1(j - 1)};
    endcase
    case (o[3:2])
      2'd0:    zv = 48'd0;
      2'd1:    zv = h_pcin[j];
      2'd2:    zv = e_p[j - 1];
      default: zv = st_c(j - 1);
    endcase
    xx = {16'd0, xv} + {63'd0, st_cyi(j - 1)};
    zz = {16'd0, zv};
    if (o[7]) begin
      cy  = (zz < xx);
      res = zz - xx;
    end else begin
      res = zz + xx;
      cy  = res[48];
    end
    e_co[j] = h_rst[j] ? 1'b0 : cy;
    if (h_rst[j] || h_rstp[j]) e_p[j] = 48'd0;
    else if (h_cep[j])         e_p[j] = res[47:0];
    else                       e_p[j] = e_p[j - 1];
  endtask

  // Apply one cycle of stimulus at the falling edge and queue what the next rising edge must produce
  task automatic drive(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                       input logic [47:0] c, input logic [47:0] pcin, input logic [7:0] op,
                       input logic rst, input logic rstp, input logic cep);
    exp_t e;
    @(negedge CLK);
    A = a; B = b; D = d; C = c; PCIN = pcin; OPMODE = op;
    BCIN = 18'($urandom);
    CARRYIN = 1'($urandom);
    {RSTA, RSTB, RSTC, RSTD, RSTM, RSTCARRYIN, RSTOPMODE} = {7{rst}};
    RSTP = rst | rstp;
    if (rst) begin
      {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'($urandom);
    end else begin
      {CEA, CEB, CEC, CED, CEM, CECARRYIN, CEOPMODE} = 7'h7F;
      CEP = cep;
    end
    k = k + 1;
    h_a[k] = a; h_b[k] = b; h_d[k] = d; h_c[k] = c; h_pcin[k] = pcin; h_op[k] = op;
    h_rst[k] = rst; h_rstp[k] = rstp; h_cep[k] = cep;
    model_p(k);
    e.bcout = st_b1(k);
    e.m     = st_m(k);
    e.p     = e_p[k];
    e.co    = e_co[k];
    sb_q.push_back(e);
  endtask

  // Monitor: one expected entry per rising edge, compared shortly after the edge
  always @(posedge CLK) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      cmp("sb_bcout", {30'd0, BCOUT}, {30'd0, mon_e.bcout});
      cmp("sb_m", {12'd0, M}, {12'd0, mon_e.m});
      cmp("sb_p", P, mon_e.p);
      cmp("sb_pcout", PCOUT, mon_e.p);
      cmp("sb_carryout", {47'd0, CARRYOUT}, {47'd0, mon_e.co});
      cmp("sb_carryoutf", {47'd0, CARRYOUTF}, {47'd0, mon_e.co});
    end
  end

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    h_rst[0] = 1'b1; h_rstp[0] = 1'b0; h_cep[0] = 1'b1;
    h_op[0] = 8'd0; h_d[0] = 18'd0; h_a[0] = 18'd0; h_b[0] = 18'd0;
    h_c[0] = 48'd0; h_pcin[0] = 48'd0; e_p[0] = 48'd0; e_co[0] = 1'b0;

    // All resets with random data and enables
    drive(18'($urandom), 18'($urandom), 18'($urandom), {16'($urandom), 32'($urandom)},
          {16'($urandom), 32'($urandom)}, 8'($urandom), 1'b1, 1'b0, 1'b1);
    after_edge();
    cmp("rst_m", {12'd0, M}, 48'd0);
    cmp("rst_p", P, 48'd0);
    cmp("rst_pcout", PCOUT, 48'd0);
    cmp("rst_bcout", {30'd0, BCOUT}, 48'd0);
    cmp("rst_carryout", {47'd0, CARRYOUT}, 48'd0);
    cmp("rst_carryoutf", {47'd0, CARRYOUTF}, 48'd0);
    for (int i = 0; i < 2; i++)
      drive(18'($urandom), 18'($urandom), 18'($urandom), {16'($urandom), 32'($urandom)},
            {16'($urandom), 32'($urandom)}, 8'($urandom), 1'b1, 1'b0, 1'b1);

    // C - A*(D-B)
    for (int i = 0; i < 4; i++) drive(18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 8'hDD, 1'b0, 1'b0, 1'b1);
    after_edge();
    cmp("t2_bcout", {30'd0, BCOUT}, 48'hF);
    cmp("t2_m", {12'd0, M}, 48'h12C);
    cmp("t2_p", P, 48'h32);
    cmp("t2_pcout", PCOUT, 48'h32);
    cmp("t2_carryout", {47'd0, CARRYOUT}, 48'd0);

    // A*(D+B) with X=Z=0
    for (int i = 0; i < 3; i++) drive(18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 8'h10, 1'b0, 1'b0, 1'b1);
    after_edge();
    cmp("t3_bcout", {30'd0, BCOUT}, 48'h23);
    cmp("t3_m", {12'd0, M}, 48'h2BC);
    cmp("t3_p", P, 48'd0);
    cmp("t3_carryout", {47'd0, CARRYOUT}, 48'd0);

    // Reload P=0x32, then accumulate P+P
    for (int i = 0; i < 4; i++) drive(18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 8'hDD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 8'h0A, 1'b0, 1'b0, 1'b1);
    after_edge();
    cmp("t4_bcout", {30'd0, BCOUT}, 48'hA);
    cmp("t4_m", {12'd0, M}, 48'hC8);
    cmp("t4_p", P, 48'h190);
    drive(18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 8'h0A, 1'b0, 1'b0, 1'b0);
    after_edge();
    cmp("t6_cep_hold", P, 48'h190);
    drive(18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 8'h0A, 1'b0, 1'b0, 1'b1);
    after_edge();
    cmp("t6_cep_resume", P, 48'h320);
    drive(18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 8'h0A, 1'b0, 1'b1, 1'b1);
    after_edge();
    cmp("t6_rstp", P, 48'd0);
    drive(18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 8'h0A, 1'b0, 1'b0, 1'b1);

    // PCIN - ({D,A,B} + 1) with borrow out
    for (int i = 0; i < 3; i++) drive(18'd5, 18'd6, 18'd25, 48'd0, 48'd3000, 8'hA7, 1'b0, 1'b0, 1'b1);
    after_edge();
    cmp("t5_bcout", {30'd0, BCOUT}, 48'd6);
    cmp("t5_m", {12'd0, M}, 48'h1E);
    cmp("t5_p", P, 48'hFE6FFFEC0BB1);
    cmp("t5_carryout", {47'd0, CARRYOUT}, 48'd1);
    cmp("t5_carryoutf", {47'd0, CARRYOUTF}, 48'd1);

    // Randomized operands, OPMODE, occasional resets and P enable drops
    for (int i = 0; i < 240; i++)
      drive(18'($urandom), 18'($urandom), 18'($urandom), {16'($urandom), 32'($urandom)},
            {16'($urandom), 32'($urandom)}, 8'($urandom),
            ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 7) != 0));

    after_edge();
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge CLK);
    #3;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d expected=0 entries left", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
